// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word
// and buffers {inst, err} in a 2-entry FIFO with valid/ready handshakes.
module inst_encoder #(
   parameter int XLEN = 32,
   parameter int ILEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      opcode,
   input  logic [9:0]      func,
   input  logic [XLEN-1:0] valC,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   input  logic [4:0]      rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ILEN-1:0] inst,
   output logic            out_err,
   output logic [15:0]     enc_count
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [31:0] NOP       = 32'h0000_0013;

   logic [31:0] v;
   logic [6:0]  f7;
   logic [2:0]  f3;
   logic        sx12;
   logic        sx13;
   logic        sx21;
   logic        is_sh;
   logic [31:0] enc;
   logic        bad;
   logic [32:0] word;

   assign v     = valC[31:0];
   assign f7    = func[9:3];
   assign f3    = func[2:0];
   // immediate fits its signed field when all upper bits match the sign
   assign sx12  = (&v[31:11]) | ~(|v[31:11]);
   assign sx13  = (&v[31:12]) | ~(|v[31:12]);
   assign sx21  = (&v[31:20]) | ~(|v[31:20]);
   assign is_sh = (f3 == 3'b001) || (f3 == 3'b101);

   always_comb begin
      enc = NOP;
      bad = 1'b0;
      unique case (opcode)
         OPC_OP: begin
            enc = {f7, rs2, rs1, f3, rd, opcode};
         end
         OPC_IMM: begin
            if (is_sh) begin
               enc = {f7, v[4:0], rs1, f3, rd, opcode};
               bad = |v[31:5];
            end else begin
               enc = {v[11:0], rs1, f3, rd, opcode};
               bad = !sx12;
            end
         end
         OPC_JALR, OPC_LOAD: begin
            enc = {v[11:0], rs1, f3, rd, opcode};
            bad = !sx12;
         end
         OPC_STORE: begin
            enc = {v[11:5], rs2, rs1, f3, v[4:0], opcode};
            bad = !sx12;
         end
         OPC_BRANCH: begin
            enc = {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], opcode};
            bad = !sx13 | v[0];
         end
         OPC_LUI, OPC_AUIPC: begin
            enc = {v[31:12], rd, opcode};
            bad = |v[11:0];
         end
         OPC_JAL: begin
            enc = {v[20], v[10:1], v[11], v[19:12], rd, opcode};
            bad = !sx21 | v[0];
         end
         default: begin
            enc = NOP;
            bad = 1'b1;
         end
      endcase
   end

   assign word = bad ? {1'b1, NOP} : {1'b0, enc};

   logic [32:0] mem0;
   logic [32:0] mem1;
   logic [32:0] head;
   logic        rptr;
   logic        wptr;
   logic [1:0]  cnt;
   logic        push;
   logic        pop;

   // no pass-through: a full FIFO refuses input even while popping
   assign in_ready  = (cnt < 2'd2);
   assign out_valid = (cnt != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign head      = rptr ? mem1 : mem0;
   assign inst      = out_valid ? ILEN'(head[31:0]) : '0;
   assign out_err   = out_valid & head[32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem0      <= '0;
         mem1      <= '0;
         rptr      <= 1'b0;
         wptr      <= 1'b0;
         cnt       <= 2'd0;
         enc_count <= 16'd0;
      end else begin
         if (push && !wptr) mem0 <= word;
         if (push && wptr)  mem1 <= word;
         if (push) wptr <= ~wptr;
         if (pop)  rptr <= ~rptr;
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
         if (push) enc_count <= enc_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: vector table, handshake corner cases,
// randomized traffic against a queue model, and counter wrap.
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  opcode = '0;
   logic [9:0]  func = '0;
   logic [31:0] valC = '0;
   logic [4:0]  rs1 = '0;
   logic [4:0]  rs2 = '0;
   logic [4:0]  rd = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] inst;
   logic        out_err;
   logic [15:0] enc_count;

   int n_cmp = 0;
   int n_err = 0;
   int exp_cnt = 0;

   inst_encoder #(.XLEN(32), .ILEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .func(func), .valC(valC),
      .rs1(rs1), .rs2(rs2), .rd(rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .inst(inst), .out_err(out_err), .enc_count(enc_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  op;
      logic [9:0]  f;
      logic [31:0] v;
      logic [4:0]  a;
      logic [4:0]  b;
      logic [4:0]  d;
      logic [31:0] ei;
      logic        ee;
   } vec_t;

   vec_t tbl[16];
   logic [32:0] q[$];

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // every RV32I format is an R-shaped word with immediate bits placed in its fields
   function automatic logic [31:0] pack(input logic [31:0] h7, input logic [31:0] f2,
                                        input logic [31:0] f1, input logic [31:0] f3,
                                        input logic [31:0] l5, input logic [31:0] op);
      return (h7 << 25) | (f2 << 20) | (f1 << 15) | (f3 << 12) | (l5 << 7) | op;
   endfunction

   function automatic logic [32:0] ref_enc(input logic [6:0] op, input logic [9:0] f,
                                           input logic [31:0] v, input logic [4:0] a,
                                           input logic [4:0] b, input logic [4:0] d);
      logic [31:0] w;
      logic        e;
      int          sv;
      logic [31:0] hi, lo, f7, f3;
      sv = $signed(v);
      f7 = 32'(f[9:3]);
      f3 = 32'(f[2:0]);
      w = 0;
      e = 0;
      case (op)
         7'h33: w = pack(f7, 32'(b), 32'(a), f3, 32'(d), 32'(op));
         7'h13, 7'h67, 7'h03: begin
            if (op == 7'h13 && (f3 == 1 || f3 == 5)) begin
               e = (v > 31);
               w = pack(f7, v % 32, 32'(a), f3, 32'(d), 32'(op));
            end else begin
               e = (sv < -2048) || (sv > 2047);
               w = pack((v >> 5) % 128, v % 32, 32'(a), f3, 32'(d), 32'(op));
            end
         end
         7'h23: begin
            e = (sv < -2048) || (sv > 2047);
            w = pack((v >> 5) % 128, 32'(b), 32'(a), f3, v % 32, 32'(op));
         end
         7'h63: begin
            e = (sv < -4096) || (sv > 4095) || (v % 2 == 1);
            hi = (((v >> 12) % 2) * 64) + ((v >> 5) % 64);
            lo = (((v >> 1) % 16) * 2) + ((v >> 11) % 2);
            w = pack(hi, 32'(b), 32'(a), f3, lo, 32'(op));
         end
         7'h37, 7'h17: begin
            e = (v % 4096 != 0);
            w = (v - (v % 4096)) | (32'(d) << 7) | 32'(op);
         end
         7'h6F: begin
            e = (sv < -1048576) || (sv > 1048575) || (v % 2 == 1);
            w = (((v >> 20) % 2) << 31) | (((v >> 1) % 1024) << 21) |
                (((v >> 11) % 2) << 20) | (((v >> 12) % 256) << 12) |
                (32'(d) << 7) | 32'(op);
         end
         default: e = 1;
      endcase
      if (e) w = 32'h13;
      return {e, w};
   endfunction

   task automatic drive(input logic [6:0] op, input logic [9:0] f, input logic [31:0] v,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
      opcode = op; func = f; valC = v; rs1 = a; rs2 = b; rd = d;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
   endtask

   logic [6:0]  ops[9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
   logic [31:0] edges[14] = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF,
                              32'd4094, 32'd4096, 32'hFFFFF000, 32'hFFFFEFFE,
                              32'h000FFFFE, 32'h00100000, 32'hFFF00000, 32'd31,
                              32'd32, 32'h0};

   logic [32:0] r;
   logic [32:0] ea, eb, ec;

   initial begin
      tbl[0]  = '{7'h33, 10'h000, 32'h0,        5'd1,  5'd2,  5'd3,  32'h002081B3, 1'b0};
      tbl[1]  = '{7'h13, 10'h000, 32'hFFFFFFFF, 5'd0,  5'd0,  5'd1,  32'hFFF00093, 1'b0};
      tbl[2]  = '{7'h63, 10'h000, 32'hFFFFFFFC, 5'd1,  5'd2,  5'd0,  32'hFE208EE3, 1'b0};
      tbl[3]  = '{7'h6F, 10'h000, 32'h3,        5'd0,  5'd0,  5'd1,  32'h00000013, 1'b1};
      tbl[4]  = '{7'h7F, 10'h000, 32'h0,        5'd0,  5'd0,  5'd0,  32'h00000013, 1'b1};
      tbl[5]  = '{7'h37, 10'h000, 32'h00001001, 5'd0,  5'd0,  5'd1,  32'h00000013, 1'b1};
      tbl[6]  = '{7'h37, 10'h000, 32'h12345000, 5'd0,  5'd0,  5'd5,  32'h123452B7, 1'b0};
      tbl[7]  = '{7'h13, 10'h001, 32'd31,       5'd2,  5'd0,  5'd2,  32'h01F11113, 1'b0};
      tbl[8]  = '{7'h13, 10'h001, 32'd32,       5'd2,  5'd0,  5'd2,  32'h00000013, 1'b1};
      tbl[9]  = '{7'h13, 10'h105, 32'd3,        5'd1,  5'd0,  5'd1,  32'h4030D093, 1'b0};
      tbl[10] = '{7'h23, 10'h002, 32'd8,        5'd2,  5'd1,  5'd9,  32'h00112423, 1'b0};
      tbl[11] = '{7'h03, 10'h002, 32'd2048,     5'd1,  5'd0,  5'd1,  32'h00000013, 1'b1};
      tbl[12] = '{7'h6F, 10'h000, 32'h800,      5'd0,  5'd0,  5'd1,  32'h001000EF, 1'b0};
      tbl[13] = '{7'h63, 10'h000, 32'h1000,     5'd1,  5'd2,  5'd0,  32'h00000013, 1'b1};
      tbl[14] = '{7'h63, 10'h000, 32'h1,        5'd1,  5'd2,  5'd0,  32'h00000013, 1'b1};
      tbl[15] = '{7'h17, 10'h000, 32'hFFFFF000, 5'd31, 5'd31, 5'd0,  32'hFFFFF017, 1'b0};

      // reset state
      #2 rst_n = 1'b0;
      #3;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_inst", inst, 0);
      chk("rst_out_err", 32'(out_err), 0);
      chk("rst_enc_count", 32'(enc_count), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;

      // vector table, one set per cycle with the consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(tbl[i].op, tbl[i].f, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].d);
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         exp_cnt++;
         chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 1);
         chk($sformatf("tbl%0d_inst", i), inst, tbl[i].ei);
         chk($sformatf("tbl%0d_err", i), 32'(out_err), 32'(tbl[i].ee));
         chk($sformatf("tbl%0d_cnt", i), 32'(enc_count), 32'(exp_cnt));
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("drain_valid", 32'(out_valid), 0);
      chk("drain_inst", inst, 0);

      // backpressure: A, B fill the FIFO, C must wait for a pop
      ea = ref_enc(7'h33, 10'h000, 0, 5'd1, 5'd2, 5'd10);
      eb = ref_enc(7'h33, 10'h100, 0, 5'd3, 5'd4, 5'd11);
      ec = ref_enc(7'h13, 10'h000, 32'd100, 5'd5, 5'd0, 5'd12);
      @(negedge clk);
      out_ready = 1'b0;
      drive(7'h33, 10'h000, 0, 5'd1, 5'd2, 5'd10);
      in_valid = 1'b1;
      @(negedge clk);
      drive(7'h33, 10'h100, 0, 5'd3, 5'd4, 5'd11);
      @(negedge clk);
      drive(7'h13, 10'h000, 32'd100, 5'd5, 5'd0, 5'd12);
      #1;
      exp_cnt += 2;
      chk("bp_full_ready", 32'(in_ready), 0);
      chk("bp_head_a", inst, ea[31:0]);
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk("bp_still_full", 32'(in_ready), 0);
      chk("bp_cnt_two", 32'(enc_count), 32'(exp_cnt));
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk("bp_after_pop_ready", 32'(in_ready), 1);
      chk("bp_head_b", inst, eb[31:0]);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      exp_cnt++;
      #1;
      chk("bp_cnt_three", 32'(enc_count), 32'(exp_cnt));
      chk("bp_head_b2", inst, eb[31:0]);
      @(negedge clk);
      #1;
      chk("bp_head_c", inst, ec[31:0]);
      @(negedge clk);
      #1;
      chk("bp_empty", 32'(out_valid), 0);

      // reset with two entries buffered
      out_ready = 1'b0;
      drive(7'h33, 10'h000, 0, 5'd1, 5'd1, 5'd1);
      in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_cnt", 32'(enc_count), 0);
      chk("mid_rst_inst", inst, 0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("post_rst_valid", 32'(out_valid), 0);
      end

      // randomized traffic against the queue model
      q.delete();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         opcode = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
         func = 10'($urandom);
         rs1 = 5'($urandom);
         rs2 = 5'($urandom);
         rd = 5'($urandom);
         case ($urandom_range(0, 5))
            0: valC = $urandom;
            1: valC = $urandom_range(0, 63);
            2: valC = 32'd0 - $urandom_range(0, 5000);
            3: valC = edges[$urandom_range(0, 13)];
            4: valC = $urandom & 32'hFFFFF000;
            default: valC = $urandom_range(0, 32'h001FFFFF) & 32'hFFFFFFFE;
         endcase
         #1;
         chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("rnd_ready", 32'(in_ready), 32'(q.size() < 2));
         chk("rnd_cnt", 32'(enc_count), 32'(exp_cnt % 65536));
         if (q.size() != 0) begin
            chk("rnd_inst", inst, q[0][31:0]);
            chk("rnd_err", 32'(out_err), 32'(q[0][32]));
         end else begin
            chk("rnd_inst_empty", inst, 0);
         end
         r = ref_enc(opcode, func, valC, rs1, rs2, rd);
         if (in_valid && q.size() < 2) begin
            if (out_ready && q.size() != 0) void'(q.pop_front());
            q.push_back(r);
            exp_cnt++;
         end else if (out_ready && q.size() != 0) begin
            void'(q.pop_front());
         end
      end

      // counter wrap after 65536 acceptances
      @(negedge clk);
      in_valid = 1'b0;
      do_reset();
      drive(7'h33, 10'h000, 0, 5'd1, 5'd2, 5'd3);
      in_valid = 1'b1;
      out_ready = 1'b1;
      repeat (65535) @(posedge clk);
      #1;
      chk("wrap_ffff", 32'(enc_count), 32'h0000FFFF);
      @(posedge clk);
      #1;
      chk("wrap_zero", 32'(enc_count), 0);
      in_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter XLEN, default 32: data width of the immediate input.
REQ-002 Parameter ILEN, default 32: width of the encoded instruction.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 in_valid  input  1: a decoded-field set is presented.
REQ-006 in_ready  output  1: the encoder accepts the set this cycle.
REQ-007 opcode  input  7: RV32I major opcode.
REQ-008 func  input  10: {funct7, funct3}.
REQ-009 valC  input  XLEN: immediate value, byte-offset form with bit 0 included.
REQ-010 rs1, rs2, rd  input  5 each: register indices.
REQ-011 out_valid  output  1: the head encoded word is valid.
REQ-012 out_ready  input  1: the consumer takes the head word this cycle.
REQ-013 inst  output  ILEN: encoded instruction word at the FIFO head.
REQ-014 out_err  output  1: the head word was substituted because of an encode error.
REQ-015 enc_count  output  16: number of input sets accepted since reset, wrapping.

Function
REQ-016 The encoder SHALL accept an input when in_valid && in_ready at a rising edge.
- in_ready = (FIFO occupancy < 2).
- There is no pass-through when the FIFO is full, even if out_ready=1.
REQ-017 Each accepted set SHALL be encoded combinationally and written into a 2-entry FIFO of {inst, err}.
- Latency is 1 cycle: a set accepted at edge N into an empty FIFO gives out_valid=1 after edge N.
REQ-018 A pop SHALL occur when out_valid && out_ready.
- Push and pop in the same cycle leave occupancy unchanged and preserve order.
REQ-019 out_valid SHALL equal (occupancy != 0); inst and out_err SHALL reflect the head entry.
- inst and out_err are 0 when the FIFO is empty.
REQ-020 OP encoding SHALL be {func[9:3], rs2, rs1, func[2:0], rd, opcode}.
REQ-021 OP_IMM, JALR and LOAD encodings SHALL be {valC[11:0], rs1, func[2:0], rd, opcode}, with one exception:
- OP_IMM with func[2:0] of 001 or 101 uses {func[9:3], valC[4:0], rs1, func[2:0], rd, opcode}.
REQ-022 STORE encoding SHALL be {valC[11:5], rs2, rs1, func[2:0], valC[4:0], opcode}.
REQ-023 BRANCH encoding SHALL be {valC[12], valC[10:5], rs2, rs1, func[2:0], valC[4:1], valC[11], opcode}.
REQ-024 LUI and AUIPC encodings SHALL be {valC[31:12], rd, opcode}.
REQ-025 JAL encoding SHALL be {valC[20], valC[10:1], valC[11], valC[19:12], rd, opcode}.
REQ-026 An encode error SHALL be flagged for any of the following:
- an opcode not in {OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE};
- a 12-bit immediate whose valC[31:11] is not all equal;
- a shift amount with valC[31:5] != 0;
- LUI/AUIPC with valC[11:0] != 0;
- BRANCH where valC[31:12] is not all equal or valC[0]=1;
- JAL where valC[31:20] is not all equal or valC[0]=1.
REQ-027 On an encode error the entry SHALL be stored as inst=0x00000013 (NOP) with err=1; otherwise err=0.
REQ-028 enc_count SHALL increment by 1 per accepted set, including error sets, and wrap from 0xFFFF to 0x0000.
REQ-029 Register-index fields unused by a format SHALL be ignored, and SHALL NOT cause an error.

Reset
REQ-030 While rst_n=0 (asserted asynchronously):
- FIFO occupancy SHALL be 0, and out_valid=0, inst=0, out_err=0, enc_count=0, in_ready=1.
REQ-031 Reset asserted mid-operation SHALL discard all buffered entries; no entry is output after release.
REQ-032 The first acceptance SHALL be possible at the first rising edge after rst_n deasserts.

Verification
REQ-033 R-type: OP, func=0, rs1=1, rs2=2, rd=3, out_ready=1 -> next cycle inst=0x002081B3, out_err=0, enc_count=1.
REQ-034 I-type and B-type: OP_IMM rd=1 rs1=0 valC=0xFFFFFFFF then BRANCH func=0 rs1=1 rs2=2 valC=0xFFFFFFFC -> inst=0xFFF00093 then 0xFE208EE3, in order.
REQ-035 Errors: JAL valC=0x3 -> inst=0x00000013, out_err=1; opcode=0x7F -> same; LUI valC=0x00001001 -> same.
REQ-036 Backpressure: out_ready=0 and three back-to-back valid sets -> first two accepted, in_ready=0 on the third; after one pop, the third is accepted and the output order is preserved.
REQ-037 Reset with 2 entries buffered -> out_valid=0 and enc_count=0 immediately (asynchronously); after release no stale word appears.
REQ-038 Wrap: 65536 accepted sets -> enc_count=0x0000.
